neuron_input_driver: RTL and testbench

NEURON_INPUT_DRIVER -- requirements
Module: neuron_input_driver

---
 rtl/neuron_pkg.sv | 35 +++
 rtl/Addition_Subtraction.sv | 91 +++++++++
 rtl/neuron_input_driver_decay.sv | 27 ++
 rtl/neuron_input_driver.sv | 123 ++++++++++++
 tb/tb_neuron_input_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron input driver and its
// floating-point helpers.
package neuron_pkg;

  typedef enum logic [2:0] {
    ST_ACCUM   = 3'd0,
    ST_DECAY   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam logic [7:0]  EXP_ZERO = 8'd0;
  localparam logic [7:0]  EXP_MAX  = 8'd255;

  // Leading-zero count of a 27-bit mantissa; returns 27 for an all-zero input.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational IEEE-754 single-precision adder/subtractor, round to nearest
// even, with subnormal, infinity and NaN handling.
module Addition_Subtraction
  import neuron_pkg::*;
(
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        add_sub,
  output logic [31:0] result
);

  logic        sign_a, sign_b, s_big, s_small, swap, eff_sub, round_up;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [7:0]  exp_a, exp_b, e_big, e_small;
  logic [23:0] m_big, m_small;
  logic [8:0]  eb_eff, es_eff, diff, exp_n, shift, exp_out;
  logic [4:0]  d_cap, lz;
  logic [53:0] align;
  logic [26:0] small_al, norm;
  logic [27:0] sum;
  logic [24:0] rounded;

  // Align, add, normalise and round; the larger magnitude is always the minuend.
  always_comb begin
    sign_a  = a_operand[31];
    sign_b  = b_operand[31] ^ add_sub;
    exp_a   = a_operand[EXP_MSB:EXP_LSB];
    exp_b   = b_operand[EXP_MSB:EXP_LSB];
    nan_a   = (exp_a == EXP_MAX) && (a_operand[22:0] != 23'd0);
    nan_b   = (exp_b == EXP_MAX) && (b_operand[22:0] != 23'd0);
    inf_a   = (exp_a == EXP_MAX) && (a_operand[22:0] == 23'd0);
    inf_b   = (exp_b == EXP_MAX) && (b_operand[22:0] == 23'd0);

    swap    = (b_operand[30:0] > a_operand[30:0]);
    s_big   = swap ? sign_b : sign_a;
    s_small = swap ? sign_a : sign_b;
    e_big   = swap ? exp_b : exp_a;
    e_small = swap ? exp_a : exp_b;
    m_big   = swap ? {exp_b != EXP_ZERO, b_operand[22:0]} : {exp_a != EXP_ZERO, a_operand[22:0]};
    m_small = swap ? {exp_a != EXP_ZERO, a_operand[22:0]} : {exp_b != EXP_ZERO, b_operand[22:0]};

    // Subnormals share the exponent of the smallest normal.
    eb_eff   = (e_big == EXP_ZERO) ? 9'd1 : {1'b0, e_big};
    es_eff   = (e_small == EXP_ZERO) ? 9'd1 : {1'b0, e_small};
    diff     = eb_eff - es_eff;
    d_cap    = (diff > 9'd27) ? 5'd27 : diff[4:0];
    align    = {m_small, 3'b000, 27'd0} >> d_cap;
    small_al = {align[53:28], align[27] | (align[26:0] != 27'd0)};

    eff_sub = s_big ^ s_small;
    sum     = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, small_al})
                      : ({1'b0, m_big, 3'b000} + {1'b0, small_al});
    lz      = lzc27(sum[26:0]);

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = eb_eff + 9'd1;
      shift = 9'd0;
    end else begin
      shift = ({4'd0, lz} > (eb_eff - 9'd1)) ? (eb_eff - 9'd1) : {4'd0, lz};
      norm  = sum[26:0] << shift;
      exp_n = eb_eff - shift;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};

    if (rounded[24]) begin
      exp_out = exp_n + 9'd1;
    end else if (rounded[23]) begin
      exp_out = exp_n;
    end else begin
      exp_out = 9'd0;
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      result = FP_QNAN;
    end else if (inf_a) begin
      result = {sign_a, EXP_MAX, 23'd0};
    end else if (inf_b) begin
      result = {sign_b, EXP_MAX, 23'd0};
    end else if (sum == 28'd0) begin
      result = {sign_a & sign_b, 31'd0};
    end else if (exp_out >= 9'd255) begin
      result = {s_big, EXP_MAX, 23'd0};
    end else begin
      result = {s_big, exp_out[7:0], rounded[22:0]};
    end
  end

endmodule

// File: rtl/neuron_input_driver_decay.sv
// Combinational power-of-two decay: lowers the exponent by SHIFT, flushing
// to signed zero on underflow and passing zero/subnormal/Inf/NaN through.
module fp_pow2_decay
  import neuron_pkg::*;
#(
  parameter int SHIFT = 1
)
(
  input  logic [31:0] value,
  output logic [31:0] decayed
);

  logic [7:0] exp_in;

  // Exponent-only rewrite; the mantissa is never touched.
  always_comb begin
    exp_in = value[EXP_MSB:EXP_LSB];
    if ((exp_in == EXP_ZERO) || (exp_in == EXP_MAX)) begin
      decayed = value;
    end else if (exp_in <= 8'(SHIFT)) begin
      decayed = {value[31], 31'd0};
    end else begin
      decayed = {value[31], exp_in - 8'(SHIFT), value[22:0]};
    end
  end

endmodule

// File: rtl/neuron_input_driver.sv
// Accumulates weighted spike events per timestep, decays the stored potential
// and hands both to an external potential adder, then captures its result.
module neuron_input_driver
  import neuron_pkg::*;
#(
  parameter int NUM_SRC     = 16,
  parameter int DECAY_SHIFT = 1,
  parameter int ADDER_WAIT  = 2,
  localparam int AW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          spike_in_valid,
  input  logic [AW-1:0] spike_in_src,
  output logic          spike_in_ready,
  input  logic          timestep_end,
  output logic [31:0]   input_weight,
  output logic [31:0]   decayed_potential,
  input  logic [31:0]   final_potential,
  input  logic          spike,
  output logic          spike_out,
  output logic          done,
  output logic          ts_overrun
);

  state_t      state;
  logic [31:0] weight [NUM_SRC];
  logic [31:0] acc, potential, decayed, acc_next, decay_out;
  logic [3:0]  wait_cnt;
  logic        accept;

  assign spike_in_ready = (state == ST_ACCUM);
  assign accept         = spike_in_valid && spike_in_ready;

  Addition_Subtraction u_acc_add (
    .a_operand (acc),
    .b_operand (weight[spike_in_src]),
    .add_sub   (1'b0),
    .result    (acc_next)
  );

  fp_pow2_decay #(.SHIFT(DECAY_SHIFT)) u_decay (
    .value   (potential),
    .decayed (decay_out)
  );

  // Weight table; an event in the same cycle reads the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        weight[i] <= FP_ZERO;
      end
    end else if (cfg_we) begin
      weight[cfg_addr] <= cfg_wdata;
    end
  end

  // Timestep sequencer with registered adder operands and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_ACCUM;
      acc               <= FP_ZERO;
      potential         <= FP_ZERO;
      decayed           <= FP_ZERO;
      input_weight      <= FP_ZERO;
      decayed_potential <= FP_ZERO;
      wait_cnt          <= 4'd0;
      done              <= 1'b0;
      spike_out         <= 1'b0;
      ts_overrun        <= 1'b0;
    end else begin
      done      <= 1'b0;
      spike_out <= 1'b0;
      if (timestep_end && (state != ST_ACCUM)) begin
        ts_overrun <= 1'b1;
      end
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc_next;
          end
          if (timestep_end) begin
            state <= ST_DECAY;
          end
        end
        ST_DECAY: begin
          decayed <= decay_out;
          state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          input_weight      <= acc;
          decayed_potential <= decayed;
          wait_cnt          <= 4'(ADDER_WAIT);
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          // Operands stay frozen while the external adder settles.
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= ST_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          potential <= final_potential;
          acc       <= FP_ZERO;
          done      <= 1'b1;
          spike_out <= spike;
          state     <= ST_ACCUM;
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_input_driver.sv
// Self-checking bench for neuron_input_driver: directed tables plus random
// timesteps checked against a real-arithmetic reference model.
module tb_neuron_input_driver;

  localparam int NUM_SRC     = 16;
  localparam int DECAY_SHIFT = 1;
  localparam int ADDER_WAIT  = 2;
  localparam int AW          = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          spike_in_valid;
  logic [AW-1:0] spike_in_src;
  logic          spike_in_ready;
  logic          timestep_end;
  logic [31:0]   input_weight;
  logic [31:0]   decayed_potential;
  logic [31:0]   final_potential;
  logic          spike;
  logic          spike_out;
  logic          done;
  logic          ts_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] w_m [NUM_SRC];
  real         acc_m;
  logic [31:0] pot_m;
  logic        ovr_m;

  typedef struct packed {
    logic [31:0] pot;
    logic [31:0] dec;
    logic        sp;
  } dvec_t;

  dvec_t tbl [8];

  neuron_input_driver #(
    .NUM_SRC(NUM_SRC), .DECAY_SHIFT(DECAY_SHIFT), .ADDER_WAIT(ADDER_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .spike_in_valid(spike_in_valid),
    .spike_in_src(spike_in_src), .spike_in_ready(spike_in_ready),
    .timestep_end(timestep_end), .input_weight(input_weight),
    .decayed_potential(decayed_potential), .final_potential(final_potential),
    .spike(spike), .spike_out(spike_out), .done(done), .ts_overrun(ts_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r2b(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic real b2r(input logic [31:0] b);
    if (b[30:23] == 8'd0) return 0.0;
    return $bitstoreal({b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] decay_m(input logic [31:0] p);
    logic [7:0] e;
    e = p[30:23];
    if (e == 8'd0 || e == 8'd255) return p;
    if (int'(e) <= DECAY_SHIFT) return {p[31], 31'd0};
    return r2b(b2r(p) / real'(2 ** DECAY_SHIFT));
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One ACCUM cycle with an optional event and an optional table write.
  task automatic step(input logic ev, input logic [AW-1:0] src, input logic we,
                      input logic [AW-1:0] addr, input logic [31:0] data);
    spike_in_valid = ev;
    spike_in_src   = src;
    cfg_we         = we;
    cfg_addr       = addr;
    cfg_wdata      = data;
    if (ev) check_int("ready_accum", int'(spike_in_ready), 1);
    tick();
    spike_in_valid = 1'b0;
    cfg_we         = 1'b0;
    if (ev) acc_m = acc_m + b2r(w_m[src]);
    if (we) w_m[addr] = data;
  endtask

  // Close a timestep, play the potential adder, and check the handshake.
  task automatic close_ts(input logic [31:0] exp_iw, input logic [31:0] exp_dp,
                          input logic [31:0] fp_ret, input logic sp_ret,
                          input logic ev, input logic [AW-1:0] ev_src, input logic overrun);
    int done_at;
    int spikes;
    done_at         = 0;
    spikes          = 0;
    final_potential = fp_ret;
    spike           = sp_ret;
    timestep_end    = 1'b1;
    spike_in_valid  = ev;
    spike_in_src    = ev_src;
    tick();
    timestep_end   = 1'b0;
    spike_in_valid = 1'b0;
    for (int n = 1; n <= ADDER_WAIT + 8 && done_at == 0; n++) begin
      tick();
      if (n >= 2 && n <= ADDER_WAIT + 2) begin
        check32("input_weight", input_weight, exp_iw);
        check32("decayed_potential", decayed_potential, exp_dp);
        check_int("ready_busy", int'(spike_in_ready), 0);
      end
      if (spike_out) spikes++;
      if (done) done_at = n;
      timestep_end = overrun && (n == 2);
    end
    timestep_end = 1'b0;
    check_int("done_latency", done_at, ADDER_WAIT + 3);
    check_int("spike_count", spikes, int'(sp_ret));
    tick();
    check_int("done_width", int'(done), 0);
    check_int("spike_width", int'(spike_out), 0);
    check_int("ready_back", int'(spike_in_ready), 1);
    ovr_m = ovr_m | overrun;
    check_int("ts_overrun", int'(ts_overrun), int'(ovr_m));
    pot_m = fp_ret;
    acc_m = 0.0;
  endtask

  initial begin
    logic [31:0]   prev;
    logic [AW-1:0] src;
    logic [AW-1:0] addr;
    logic          we_r;
    logic          ev;
    int            nev;

    tbl[0] = '{32'h42800000, 32'h42000000, 1'b0};
    tbl[1] = '{32'h00800000, 32'h00000000, 1'b1};
    tbl[2] = '{32'h80800000, 32'h80000000, 1'b0};
    tbl[3] = '{32'h01000000, 32'h00800000, 1'b1};
    tbl[4] = '{32'h7F800000, 32'h7F800000, 1'b0};
    tbl[5] = '{32'h00000001, 32'h00000001, 1'b0};
    tbl[6] = '{32'hC2800000, 32'hC2000000, 1'b1};
    tbl[7] = '{32'h7FC00001, 32'h7FC00001, 1'b0};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = 32'h0;
    spike_in_valid = 1'b0; spike_in_src = '0; timestep_end = 1'b0;
    final_potential = 32'h0; spike = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) w_m[i] = 32'h0;
    acc_m = 0.0; pot_m = 32'h0; ovr_m = 1'b0;

    tick();
    check32("rst_input_weight", input_weight, 32'h0);
    check32("rst_decayed", decayed_potential, 32'h0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_spike_out", int'(spike_out), 0);
    check_int("rst_overrun", int'(ts_overrun), 0);
    check_int("rst_ready", int'(spike_in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Basic accumulation then spike capture of 1.0.
    step(1'b0, '0, 1'b1, 4'd3, 32'h3F800000);
    step(1'b0, '0, 1'b1, 4'd5, 32'h40000000);
    step(1'b1, 4'd3, 1'b0, '0, 32'h0);
    step(1'b1, 4'd5, 1'b0, '0, 32'h0);
    close_ts(32'h40400000, 32'h00000000, 32'h3F800000, 1'b1, 1'b0, '0, 1'b0);
    close_ts(32'h00000000, 32'h3F000000, 32'h00000000, 1'b0, 1'b0, '0, 1'b0);
    close_ts(32'h3F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 4'd3, 1'b0);

    // Decay corner table, each entry observed one timestep after capture.
    prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      close_ts(32'h0, prev, tbl[i].pot, tbl[i].sp, 1'b0, '0, 1'b0);
      prev = tbl[i].dec;
    end
    close_ts(32'h0, prev, 32'h0, 1'b0, 1'b0, '0, 1'b0);

    // Write and read of one address in the same cycle sees the old weight.
    step(1'b0, '0, 1'b1, 4'd7, 32'h3F800000);
    step(1'b1, 4'd7, 1'b1, 4'd7, 32'h40800000);
    step(1'b1, 4'd7, 1'b0, '0, 32'h0);
    close_ts(32'h40A00000, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0);

    // Overrun during WAIT, then sticky across a clean timestep.
    close_ts(32'h0, 32'h0, 32'h3F800000, 1'b0, 1'b0, '0, 1'b1);
    close_ts(32'h0, 32'h3F000000, 32'h0, 1'b0, 1'b0, '0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      nev = $urandom_range(0, 6);
      for (int e = 0; e < nev; e++) begin
        src  = AW'($urandom_range(0, NUM_SRC - 1));
        we_r = ($urandom_range(0, 2) == 0);
        addr = ($urandom_range(0, 1) == 0) ? src : AW'($urandom_range(0, NUM_SRC - 1));
        step(1'b1, src, we_r, addr, r2b(real'(int'($urandom_range(0, 128)) - 64) / 4.0));
        if ($urandom_range(0, 2) == 0) step(1'b0, '0, 1'b0, '0, 32'h0);
      end
      ev  = 1'($urandom_range(0, 1));
      src = AW'($urandom_range(0, NUM_SRC - 1));
      if (ev) acc_m = acc_m + b2r(w_m[src]);
      close_ts(r2b(acc_m), decay_m(pot_m), $urandom(), 1'($urandom_range(0, 1)), ev, src, 1'b0);
    end

    // Reset in the middle of WAIT aborts the timestep silently.
    step(1'b1, 4'd3, 1'b0, '0, 32'h0);
    final_potential = 32'h3F800000;
    spike           = 1'b1;
    timestep_end    = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check32("mid_rst_input_weight", input_weight, 32'h0);
    check32("mid_rst_decayed", decayed_potential, 32'h0);
    check_int("mid_rst_overrun", int'(ts_overrun), 0);
    check_int("mid_rst_ready", int'(spike_in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_int("mid_rst_done", int'(done), 0);
      check_int("mid_rst_spike_out", int'(spike_out), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) w_m[i] = 32'h0;
    acc_m = 0.0; pot_m = 32'h0; ovr_m = 1'b0;
    tick();
    step(1'b1, 4'd3, 1'b0, '0, 32'h0);
    close_ts(r2b(acc_m), decay_m(pot_m), 32'h40000000, 1'b1, 1'b0, '0, 1'b0);
    close_ts(32'h0, 32'h3F800000, 32'h0, 1'b0, 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
